// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan controller.
//   - seg_bit_e : bit position of each segment inside the 7-bit seg bus,
//                 ordered {g,f,e,d,c,b,a} (a is bit 0, g is bit 6).
//   - SEG_OFF   : all segments dark (active low).
//   - SEG_0..F  : active-low glyphs for the hex digits 0-F.
// ---------------------------------------------------------------------------
package seg7_pkg;

  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_HA = 7'b0001000;
  localparam logic [6:0] SEG_HB = 7'b0000011;
  localparam logic [6:0] SEG_HC = 7'b1000110;
  localparam logic [6:0] SEG_HD = 7'b0100001;
  localparam logic [6:0] SEG_HE = 7'b0000110;
  localparam logic [6:0] SEG_HF = 7'b0001110;

endpackage

// File: rtl/seg7_hex.sv
// ---------------------------------------------------------------------------
// seg7_hex
// Combinational hex (0-F) to seven-segment decoder, active-low output.
// Ports:
//   nibble  in   4  hex digit to display
//   seg     out  7  {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module seg7_hex
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: default assignment before the case guarantees every path drives
    // seg, so no latch can be inferred even if the case were edited later.
    seg = SEG_OFF;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_HA;
      4'hB: seg = SEG_HB;
      4'hC: seg = SEG_HC;
      4'hD: seg = SEG_HD;
      4'hE: seg = SEG_HE;
      4'hF: seg = SEG_HF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
// Time-multiplexed controller for NDIG common-anode seven-segment digits on a
// shared segment bus. Hex decode, per-digit decimal point and blanking, and a
// double buffer so the shown image only changes at a frame boundary.
// Parameters:
//   NDIG  number of digits (1-8)
//   DIV   clk cycles each digit is lit (>= 2)
// Ports:
//   clk       in   1       system clock, rising edge
//   reset     in   1       asynchronous, active-high reset
//   load      in   1       strobe: capture value/dp_in/blank_in
//   value     in   4*NDIG  hex nibbles, digit 0 rightmost
//   dp_in     in   NDIG    decimal point request, 1 = lit
//   blank_in  in   NDIG    force digit dark, 1 = dark
//   seg       out  7       {g..a}, active low
//   dp        out  1       decimal point, active low
//   an        out  NDIG    digit enables, active low, one-hot-low
//   frame     out  1       one-cycle pulse when scan wraps to digit 0
// Build option:
//   SEG7_LZ_BLANK_EN  enables leading-zero suppression (mask computed when the
//                     display buffer is updated, so no extra output latency).
// ---------------------------------------------------------------------------
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DIV  = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*NDIG-1:0]   value,
  input  logic [NDIG-1:0]     dp_in,
  input  logic [NDIG-1:0]     blank_in,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [NDIG-1:0]     an,
  output logic                frame
);

  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DIVW = $clog2(DIV);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);
  localparam logic [DIVW-1:0] LAST_DIV = DIVW'(DIV - 1);

  logic [DIVW-1:0]   div_cnt;
  logic [IDXW-1:0]   idx;
  logic              tick;
  logic              boundary;
  logic              commit;

  logic [4*NDIG-1:0] pend_value;
  logic [NDIG-1:0]   pend_dp;
  logic [NDIG-1:0]   pend_blank;
  logic              pend;

  logic [4*NDIG-1:0] disp_value;
  logic [NDIG-1:0]   disp_dp;
  logic [NDIG-1:0]   disp_blank;

  logic [4*NDIG-1:0] next_value;
  logic [NDIG-1:0]   next_dp;
  logic [NDIG-1:0]   next_blank;

  logic [NDIG-1:0]   dark;
  logic [3:0]        cur_nibble;
  logic [6:0]        hex_seg;

  assign tick     = (div_cnt == LAST_DIV);
  assign boundary = tick && (idx == LAST_IDX);
  // A load landing on the boundary tick bypasses pending and goes straight
  // to the display buffer.
  assign commit   = boundary && (pend || load);

  always_comb begin
    if (load) begin
      next_value = value;
      next_dp    = dp_in;
      next_blank = blank_in;
    end else begin
      next_value = pend_value;
      next_dp    = pend_dp;
      next_blank = pend_blank;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of always_ff evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  // Both buffers are small register banks (not RAM), so they take the reset
  // and reset discards any pending image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend       <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else begin
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
      end
      if (commit) begin
        disp_value <= next_value;
        disp_dp    <= next_dp;
        disp_blank <= next_blank;
        pend       <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [NDIG-1:0] lz_mask;

  // Walk down from the top digit; suppression runs while nibbles are zero
  // with no decimal point. Digit 0 is never suppressed.
  function automatic logic [NDIG-1:0] lz_calc(input logic [4*NDIG-1:0] v,
                                              input logic [NDIG-1:0]   d);
    logic [NDIG-1:0] m;
    logic            run;
    m   = '0;
    run = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      run  = run && (v[4*i +: 4] == 4'h0) && !d[i];
      m[i] = run;
    end
    return m;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lz_mask <= '0;
    else if (commit) lz_mask <= lz_calc(next_value, next_dp);
  end

  assign dark = disp_blank | lz_mask;
`else
  assign dark = disp_blank;
`endif

  assign cur_nibble = disp_value[4*idx +: 4];

  seg7_hex u_hex (
    .nibble (cur_nibble),
    .seg    (hex_seg)
  );

  // Outputs lag idx and the display buffer by one cycle; a dark digit keeps
  // its anode slot so scan timing stays uniform.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg   <= SEG_OFF;
      dp    <= 1'b1;
      an    <= '1;
      frame <= 1'b0;
    end else begin
      an    <= ~(NDIG'(1) << idx);
      frame <= boundary;
      if (dark[idx]) begin
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        seg <= hex_seg;
        dp  <= ~disp_dp[idx];
      end
    end
  end

endmodule
